// File: rtl/dco_pkg.sv
// dco_pkg: shared constants, helper function and channel-state type for the dco_bank oscillator array
package dco_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int MAX_ACC_W = 32;
  localparam int MAX_CODE_W = 16;
  typedef struct packed {
    logic [MAX_ACC_W-1:0]  acc;
    logic [MAX_CODE_W-1:0] active;
    logic [MAX_CODE_W-1:0] pending;
    logic                  flag;
  } dco_ch_state_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dco_channel.sv
// dco_channel: one phase-accumulator oscillator whose new code loads only at a phase wrap
// ports: clk, rst_n (async low); ena run enable; en channel enable (low clears phase);
// dither adds one LSB to a nonzero step; wr/wr_code load the pending code;
// busy = pending code waiting; dco = accumulator MSB
module dco_channel import dco_pkg::*; #(
  parameter int CODE_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              en,
  input  logic              dither,
  input  logic              wr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              busy,
  output logic              dco
);
  logic [ACC_W-1:0]  acc;
  logic [CODE_W-1:0] active, pending;
  logic [ACC_W:0]    sum;
  logic              apply;
  assign sum = {1'b0, acc} + (ACC_W+1)'(active) + (ACC_W+1)'(dither & |active);
  // a disabled channel swaps codes at once, even while the bank is paused
  assign apply = busy & (~en | (ena & (sum[ACC_W] | ~|active)));
  assign dco = acc[ACC_W-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      active <= '0;
      pending <= '0;
      busy <= 1'b0;
    end else begin
      if (ena) acc <= en ? sum[ACC_W-1:0] : '0;
      if (wr) begin
        pending <= wr_code;
        busy <= 1'b1;
      end else if (apply) begin
        active <= pending;
        busy <= 1'b0;
      end
    end
endmodule

// File: rtl/dco_bank.sv
// dco_bank: NUM_CH phase-accumulator oscillators with a ready/valid code port and a gated edge meter
// ports: clk, rst_n (async low); ena global run; ch_en per-channel enable;
// wr_valid/wr_ready/wr_ch/wr_code code write port; dco_out square waves;
// meas_ch metered channel; meas_count/meas_valid last window's rising-edge count
// build option: define DCO_DITHER_EN to add LFSR dither to every nonzero step
module dco_bank import dco_pkg::*; #(
  parameter int NUM_CH    = 4,
  parameter int CODE_W    = 8,
  parameter int ACC_W     = 16,
  parameter int GATE_LOG2 = 10,
  parameter int MEAS_W    = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [clog2_min1(NUM_CH)-1:0]  wr_ch,
  input  logic [CODE_W-1:0]              wr_code,
  output logic [NUM_CH-1:0]              dco_out,
  input  logic [clog2_min1(NUM_CH)-1:0]  meas_ch,
  output logic [MEAS_W-1:0]              meas_count,
  output logic                           meas_valid
);
  localparam int CH_W = clog2_min1(NUM_CH);
  logic [NUM_CH-1:0]    busy;
  logic [2**CH_W-1:0]   busy_pad, dco_pad;
  logic                 dither, meas_bit, meas_prev, rise;
  logic [CH_W-1:0]      meas_q;
  logic [GATE_LOG2-1:0] win;
  logic [MEAS_W-1:0]    edges, edges_nx;
  // padding makes out-of-range channel numbers read as idle, so their writes are accepted and dropped
  assign busy_pad = (2**CH_W)'(busy);
  assign dco_pad = (2**CH_W)'(dco_out);
  assign wr_ready = ~busy_pad[wr_ch];
  assign meas_bit = int'(meas_ch) < NUM_CH ? dco_pad[meas_ch] : dco_out[0];
  assign rise = meas_bit & ~meas_prev;
  assign edges_nx = edges + MEAS_W'(rise & ~&edges);
`ifdef DCO_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (ena) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dco_channel #(.CODE_W(CODE_W), .ACC_W(ACC_W)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .en(ch_en[i]),
      .dither(dither),
      .wr(wr_valid & wr_ready & (int'(wr_ch) == i)),
      .wr_code(wr_code),
      .busy(busy[i]),
      .dco(dco_out[i])
    );
  end
  // a change of meas_ch abandons the running window without reporting it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win <= '0;
      edges <= '0;
      meas_prev <= 1'b0;
      meas_q <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (ena) begin
        meas_prev <= meas_bit;
        meas_q <= meas_ch;
        if (meas_ch != meas_q) begin
          win <= '0;
          edges <= '0;
        end else if (&win) begin
          meas_count <= edges_nx;
          meas_valid <= 1'b1;
          win <= '0;
          edges <= '0;
        end else begin
          win <= win + 1'b1;
          edges <= edges_nx;
        end
      end
    end
endmodule

// File: doc/dco_bank.md
Name: dco_bank

Overview:
- Multi-channel, parametrised successor to the single 8-bit-code DCO.
- NUM_CH independent phase-accumulator oscillators, each with its own tuning code.
- Codes are loaded through a ready/valid write port. A new code takes effect only at the channel's next phase wrap, so frequency changes are glitch-free.
- A built-in gated frequency meter counts rising edges of one selected channel per fixed window. Sits between the ui_in/uio_in decode and the uo_out pins of the top-level wrapper.

Parameters:
- NUM_CH, 4: number of oscillator channels (≥1).
- CODE_W, 8: tuning-code width.
- ACC_W, 16: phase-accumulator width (≥ CODE_W+1).
- GATE_LOG2, 10: measurement window = 2^GATE_LOG2 clk cycles.
- MEAS_W, 12: edge-count result width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global run enable
- ch_en  in  NUM_CH  per-channel enable
- wr_valid  in  1  code write request
- wr_ready  out  1  write accepted when high with wr_valid
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
- wr_code  in  CODE_W  new tuning code
- dco_out  out  NUM_CH  square-wave outputs (accumulator MSB)
- meas_ch  in  $clog2(NUM_CH) (min 1)  channel under measurement
- meas_count  out  MEAS_W  last window's edge count
- meas_valid  out  1  one-cycle pulse when meas_count updates

Behaviour:
- Reset (async, rst_n=0): all accumulators, active codes and pending codes = 0; pending flags clear; dco_out=0; meas_count=0; meas_valid=0; window counter=0.
- Per channel, each clk with ena=1 and ch_en[i]=1: acc <= acc + zero-extend(active_code) mod 2^ACC_W; dco_out[i] = acc[ACC_W-1] (registered; output frequency = f_clk·code/2^ACC_W).
- active_code=0: accumulator holds, output frozen at its current level.
- ena=0: every accumulator, output, pending flag and meter state holds.
- ch_en[i]=0: acc[i] cleared to 0 and dco_out[i]=0 on the next cycle. Active and pending codes are retained.
- Write handshake: wr_ready = ~pending_flag[wr_ch] (combinational on wr_ch). A transfer is wr_valid & wr_ready; it stores wr_code in pending[wr_ch] and sets the flag.
- wr_ch ≥ NUM_CH: transfer is accepted and discarded.
- Pending apply: when the flag is set, active_code <= pending and the flag clears on the first cycle in which one of these holds:
  - (a) the accumulator add overflows (wrap);
  - (b) active_code=0;
  - (c) ch_en[i]=0.
  The new code is used from the following cycle. Applying requires ena=1, except case (c).
- A transfer and an apply on the same channel in the same cycle cannot occur, because wr_ready is low while the flag is set.
- Meter: window counter runs 0..2^GATE_LOG2-1 when ena=1. A rising edge of dco_out[meas_ch] increments the edge counter, which saturates at 2^MEAS_W-1.
- Window end (counter at its maximum): meas_count <= edge count, including an edge in that same cycle. meas_valid=1 for that cycle; edge counter and window counter reset to 0.
- meas_ch change: window and edge counter restart next cycle; no meas_valid for the aborted window. meas_ch ≥ NUM_CH reads as channel 0.

Optional Feature:
- DCO_DITHER_EN defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances each ena cycle.
  - Its bit 0 is added to the LSB of the step of every channel with active_code≠0. This spreads spurs.
  - Mean frequency rises by f_clk/2^(ACC_W+1).
- Undefined: step is exactly active_code. No LFSR logic is present.

Decomposition:
- dco_pkg:
  - LFSR seed and tap constants;
  - clog2-with-minimum-1 helper function;
  - per-channel struct typedef (acc, active, pending, flag).
- Sub-module dco_channel: one accumulator, pending-code logic and output register, instantiated NUM_CH times via generate.
- Meter and write-port decode stay in dco_bank.

Test Plan (NUM_CH=4, CODE_W=8, ACC_W=10, GATE_LOG2=8, MEAS_W=12, dither off unless stated):
- Reset mid-run: assert rst_n=0 asynchronously between edges → dco_out=0, meas_count=0, meas_valid=0 immediately; wr_ready=1.
- Write ch0 code 64, ch_en=4'b0001 → code applies in 1 cycle (active was 0). dco_out[0] toggles every 8 cycles (period 16). Steady-state meas_count=16 with meas_valid pulsing every 256 cycles.
- Write code 128 to ch0 while running at 64 → wr_ready for ch0 low until the next wrap. Period changes from 16 to 8 exactly at the wrap, with no output pulse shorter than 4 cycles. Second write while pending is stalled.
- Channels 1..3 at codes 1, 2, 255 with meas_ch stepped 1→2→3 → after each full window, meas_count = 0 or 1, then 0 or 1, then 63 or 64 (phase-dependent). No valid pulse for aborted windows.
- ena=0 for 50 cycles mid-window → outputs and counters frozen. Resume continues with the same phase, and the window completes 50 cycles later.
- DCO_DITHER_EN, ch0 code 64 → average count over 8 windows lies within 16..17, exceeding the undithered count.
